// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared state encoding, RV32M funct3 codes and helpers for the
// iterative multiply/divide unit.
`default_nettype none

package mdu_seq_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  // Magnitude of a signed operand; unsigned operands pass through untouched.
  function automatic logic [MDU_XLEN-1:0] mag(input logic [MDU_XLEN-1:0] v,
                                              input logic is_signed);
    return (is_signed && v[MDU_XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_addsub.sv
// mdu_addsub: combinational W-bit adder/subtractor with carry-out; on a
// subtract, cout=1 means the difference is non-negative (no borrow).
`default_nettype none

module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  assign sum   = full[W-1:0];
  assign cout  = full[W];

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// mdu_seq: radix-2 iterative RV32M multiply/divide unit with pipeline stall
// and single-cycle result strobe. Rev 1.0.
`default_nettype none

module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            req_ready,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  mdu_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   opb;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi;      // product accumulator or partial remainder
  logic [XLEN-1:0]   lo;      // multiplier or quotient
  logic              neg;
  logic [XLEN-1:0]   result;

  logic              accept, is_div, last_iter;
  logic              s1, s2, div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     add_a, add_b, add_sum;
  logic              add_cout;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  assign accept    = req_valid & (state == MDU_IDLE) & ~flush;
  assign is_div    = op[2];
  assign last_iter = (cnt == CNT_W'(XLEN - 1));

  assign s1 = (req_op == MDU_MULH) | (req_op == MDU_MULHSU) |
              (req_op == MDU_DIV)  | (req_op == MDU_REM);
  assign s2 = (req_op == MDU_MULH) | (req_op == MDU_DIV) | (req_op == MDU_REM);

  assign div_zero = (req_rs2 == '0);
  assign div_ovf  = (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
  // DIV and REM are the even signed ops; op[1] separates remainder from quotient.
  assign special  = req_op[2] & (div_zero | (div_ovf & ~req_op[0]));
  assign special_val = div_zero ? (req_op[1] ? req_rs1 : '1)
                                : (req_op[1] ? '0 : req_rs1);

  assign add_a = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
  assign add_b = {1'b0, opb};

  mdu_addsub #(.W(XLEN + 1)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (is_div),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign prod_s = neg ? (~{hi, lo} + 1'b1) : {hi, lo};
  assign quot_s = neg ? (~lo + 1'b1) : lo;
  assign rem_s  = neg ? (~hi + 1'b1) : hi;

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (accept) state_nxt = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (last_iter) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_DONE;
      MDU_DONE: state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
    if (flush) state_nxt = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op     <= '0;
      opb    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (accept) begin
          op     <= req_op;
          opb    <= mag(req_rs2, s2);
          lo     <= mag(req_rs1, s1);
          hi     <= '0;
          cnt    <= '0;
          // Remainder takes the dividend's sign only.
          neg    <= (s1 & req_rs1[XLEN-1]) ^
                    (s2 & req_rs2[XLEN-1] & ~(req_op == MDU_REM));
          result <= special_val;
        end
        MDU_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            hi <= add_cout ? add_sum[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], add_cout};
          end else if (lo[0]) begin
            hi <= add_sum[XLEN:1];
            lo <= {add_sum[0], lo[XLEN-1:1]};
          end else begin
            hi <= {1'b0, hi[XLEN-1:1]};
            lo <= {hi[0], lo[XLEN-1:1]};
          end
        end
        MDU_FIX: begin
          case (op)
            MDU_MUL:                         result <= prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result <= prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               result <= quot_s;
            default:                         result <= rem_s;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == MDU_IDLE);
  assign stall      = ((state == MDU_IDLE) & req_valid & ~flush) |
                      (state == MDU_CALC) | (state == MDU_FIX);
  assign resp_valid = (state == MDU_DONE) & ~flush;
  assign resp_data  = resp_valid ? result : '0;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vector table, corner-case sequences and randomized ops
// checked against an arithmetic reference model.
`default_nettype none

module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic        req_ready, stall, resp_valid;
  logic [31:0] resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .flush      (flush),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < MDU_DIV) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((op == MDU_DIV) || (op == MDU_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      MDU_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      MDU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MDU_MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      MDU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      MDU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One complete operation: accept, wait (bounded) for the strobe, check
  // data, latency, stall duration and the handshake around DONE.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, stall_cnt, exp_lat;
    logic dirty;
    exp_lat = is_special(op, a, b) ? 1 : 34;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    #1;
    stall_cnt = stall ? 1 : 0;
    dirty = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      if (stall) stall_cnt++;
      if (resp_data != 32'd0) dirty = 1'b1;
      @(negedge clk);
      #1;
      lat++;
    end
    check({name, " valid"}, 32'(resp_valid), 32'd1);
    check({name, " data"}, resp_data, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check({name, " done_stall_ready"}, {30'd0, stall, req_ready}, 32'd0);
    check({name, " idle_data_zero"}, 32'(dirty), 32'd0);
    @(negedge clk);
    #1;
    check({name, " after_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check({name, " no_resp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{MDU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{MDU_DIVU,   32'd100,        32'd7,         32'd14};
    vecs[7]  = '{MDU_REMU,   32'd100,        32'd7,         32'd2};
    vecs[8]  = '{MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{MDU_REMU,   32'd5,          32'd0,         32'd5};
    vecs[10] = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{MDU_REM,    32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7};
    vecs[14] = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[15] = '{MDU_DIV,    32'h8000_0000,  32'd2,         32'hC000_0000};

    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_op = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {resp_data[29:0], req_ready, stall}, 32'd2);
    check("reset valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush in the middle of CALC, then a normal op afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MUL; req_rs1 = 32'd5; req_rs2 = 32'd6;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("flush_calc stall_before", 32'(stall), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_calc ready_stall", {30'd0, req_ready, stall}, 32'd2);
    watch_quiet("flush_calc", 40);
    run_op("mul_after_flush", MDU_MUL, 32'd3, 32'd4, 32'd12);

    // Flush coincident with a request in IDLE.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = MDU_DIVU; req_rs1 = 32'd9; req_rs2 = 32'd2;
    #1;
    check("flush_idle stall", 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle ready_stall", {30'd0, req_ready, stall}, 32'd2);
    watch_quiet("flush_idle", 40);

    // Flush during DONE suppresses the strobe.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_DIVU; req_rs1 = 32'd100; req_rs2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (33) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done resp", {resp_data[30:0], resp_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_done ready", 32'(req_ready), 32'd1);
    watch_quiet("flush_done", 5);

    // Reset asserted while in FIX.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MUL; req_rs1 = 32'd11; req_rs2 = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (32) @(negedge clk);
    #1;
    check("rst_fix stall_in_fix", 32'(stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_fix outputs", {resp_data[29:0], req_ready, stall}, 32'd2);
    check("rst_fix valid", 32'(resp_valid), 32'd0);
    watch_quiet("rst_fix", 5);

    // Reset held with a request pending must not accept it.
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_op = MDU_MULHU; req_rs1 = 32'd1; req_rs2 = 32'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_hold ready_stall", {30'd0, req_ready, stall}, 32'd2);
    watch_quiet("rst_hold", 5);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] edges[5];
      edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(0, 20)); end
        1:       begin a = $urandom; b = $urandom; end
        default: begin a = edges[$urandom_range(0, 4)]; b = edges[$urandom_range(0, 4)]; end
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
